period_meter32: RTL

Measures the interval, in `clk` cycles, between consecutive rising edges of an external pulse input and reports each completed interval with a one-cycle strobe. It is the receive-side counterpart of the periodic pulse timer. It sits on pulse inputs that come from other timers or off-chip sources, to check or recover their period. An internal synchronizer makes the input safe to connect asynchronously.

---
 rtl/period_meter32.sv | 79 +++++++
 1 files changed

// File: rtl/period_meter32.sv
// period_meter32: measures clk cycles between rising edges of an asynchronous pulse input,
// reporting each interval with a valid strobe and flagging edge-free windows with timeout.
module period_meter32 #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MAX_PERIOD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_pulse,
  output logic [31:0] period_out,
  output logic        valid,
  output logic        timeout,
  output logic        measuring
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic hist, pulse_edge, valid_n, timeout_n;
  logic [31:0] cnt, cnt_n, period_n;
  assign pulse_edge = sync[SYNC_STAGES-1] & ~hist;
  assign measuring = state == MEASURE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      hist <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      period_out <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_pulse};
      hist <= sync[SYNC_STAGES-1];
      state <= state_n;
      cnt <= cnt_n;
      period_out <= period_n;
      valid <= valid_n;
      timeout <= timeout_n;
    end
  end
  // enable low overrides everything; in MEASURE an edge beats the timeout
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    period_n = period_out;
    valid_n = 1'b0;
    timeout_n = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          cnt_n = '0;
        end
        ARM: if (pulse_edge) begin
          state_n = MEASURE;
          cnt_n = 32'd1;
        end
        MEASURE: begin
          if (pulse_edge) begin
            period_n = cnt;
            valid_n = 1'b1;
            cnt_n = 32'd1;
          end else if (cnt == MAX_PERIOD) begin
            timeout_n = 1'b1;
            cnt_n = '0;
            state_n = ARM;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
